// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master engine: state encoding, byte geometry,
// divider limits and the divider counter width helper.
package spi_pkg;

   localparam logic [2:0] ENC_IDLE  = 3'd0;
   localparam logic [2:0] ENC_LEAD  = 3'd1;
   localparam logic [2:0] ENC_SHIFT = 3'd2;
   localparam logic [2:0] ENC_DONE  = 3'd3;
   localparam logic [2:0] ENC_TRAIL = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = ENC_IDLE,
      LEAD  = ENC_LEAD,
      SHIFT = ENC_SHIFT,
      DONE  = ENC_DONE,
      TRAIL = ENC_TRAIL
   } state_t;

   localparam int CLK_DIV_MIN = 2;
   localparam int BYTE_BITS   = 8;

   // A divide-by-2 counter still needs one bit.
   function automatic int cnt_width(input int div);
      return (div <= 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Divider for the SPI engine: one-cycle tick every CLK_DIV clocks, restarted
// by a synchronous clear so every state begins with a full period.
module spi_tick_gen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int DIV = (CLK_DIV < CLK_DIV_MIN) ? CLK_DIV_MIN : CLK_DIV;
   localparam int CW  = cnt_width(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clr || (cnt_q == LAST)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/spi_master_engine.sv
// SPI mode-0 master shift engine: pops bytes from the TX FIFO, shifts them out
// on MOSI while capturing MISO, and strobes each received byte into the RX FIFO.
module spi_master_engine
   import spi_pkg::*;
#(
   parameter int CLK_DIV   = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] txdin,
   input  logic       txgo,
   output logic       txrdy,
   output logic [7:0] rxdout,
   output logic       rxnew,
   input  logic       MISO,
   output logic       MOSI,
   output logic       SCLK,
   output logic       SS1
);

   localparam int HALF_W = $clog2(2 * BYTE_BITS);
   localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * BYTE_BITS - 1);

   function automatic logic head_bit(input logic [7:0] b);
      return MSB_FIRST ? b[7] : b[0];
   endfunction

   function automatic logic [7:0] shift_in(input logic [7:0] b, input logic s);
      return MSB_FIRST ? {b[6:0], s} : {s, b[7:1]};
   endfunction

   state_t            state_q, state_d;
   logic              tick;
   logic              cnt_clr;
   logic [HALF_W-1:0] half_q;
   logic [7:0]        sr_q;
   logic              mosi_q, sclk_q, ss1_q;
   logic [7:0]        rxdout_q;

   logic load, rise_ev, fall_ev, last_fall, to_trail, trail_end;

   spi_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      rise_ev   = 1'b0;
      fall_ev   = 1'b0;
      last_fall = 1'b0;
      to_trail  = 1'b0;
      trail_end = 1'b0;
      case (state_q)
         IDLE: begin
            if (txgo) begin
               load    = 1'b1;
               state_d = LEAD;
            end
         end
         LEAD: begin
            if (tick) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // Even half-periods end on a rising SCLK edge, odd ones on a falling edge.
            if (tick) begin
               if (!half_q[0]) begin
                  rise_ev = 1'b1;
               end else begin
                  fall_ev = 1'b1;
                  if (half_q == LAST_HALF) begin
                     last_fall = 1'b1;
                     state_d   = DONE;
                  end
               end
            end
         end
         DONE: begin
            if (txgo) begin
               load    = 1'b1;
               state_d = SHIFT;
            end else begin
               to_trail = 1'b1;
               state_d  = TRAIL;
            end
         end
         TRAIL: begin
            if (tick) begin
               trail_end = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Restart the divider on every state change so each phase gets full periods.
   assign cnt_clr = (state_d != state_q);

   always_ff @(posedge clk) begin
      if (rst || (state_q != SHIFT)) begin
         half_q <= '0;
      end else if (tick) begin
         half_q <= half_q + 1'b1;
      end
   end

   // Shift register carries no reset: it is always reloaded before use.
   always_ff @(posedge clk) begin
      if (load) begin
         sr_q <= txdin;
      end else if (rise_ev) begin
         sr_q <= shift_in(sr_q, MISO);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mosi_q   <= 1'b1;
         sclk_q   <= 1'b0;
         ss1_q    <= 1'b1;
         rxdout_q <= 8'h00;
      end else begin
         if (load) begin
            mosi_q <= head_bit(txdin);
            ss1_q  <= 1'b0;
         end
         if (rise_ev) begin
            sclk_q <= 1'b1;
         end
         if (fall_ev) begin
            sclk_q <= 1'b0;
            if (!last_fall) begin
               mosi_q <= head_bit(sr_q);
            end
         end
         if (last_fall) begin
            rxdout_q <= sr_q;
         end
         if (to_trail) begin
            mosi_q <= 1'b1;
         end
         if (trail_end) begin
            ss1_q <= 1'b1;
         end
      end
   end

   assign txrdy  = (state_q == IDLE) || (state_q == DONE);
   assign rxnew  = (state_q == DONE);
   assign rxdout = rxdout_q;
   assign MOSI   = mosi_q;
   assign SCLK   = sclk_q;
   assign SS1    = ss1_q;

endmodule

// File: tb/tb_spi_master_engine.sv
// Bench for spi_master_engine: three configurations share one clock, a TX FIFO
// model feeds the selected one, and results are checked against a timing/bit model.
module tb_spi_master_engine;

   function automatic int div_of(input int g);
      return (g == 0) ? 2 : (g == 1) ? 4 : 3;
   endfunction
   function automatic bit msb_of(input int g);
      return (g == 2) ? 1'b0 : 1'b1;
   endfunction

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic [1:0] sel = 2'd0;
   logic [7:0] txdin = 8'h00;
   logic       drv_go = 1'b0;
   logic [2:0] txgo_a, txrdy_a, rxnew_a, miso_a, mosi_a, sclk_a, ss1_a;
   logic [7:0] rxdout_a [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign txgo_a[g] = (sel == 2'(g)) && drv_go;
      spi_master_engine #(
         .CLK_DIV   (div_of(g)),
         .MSB_FIRST (msb_of(g))
      ) u_dut (
         .clk    (clk),
         .rst    (rst),
         .txdin  (txdin),
         .txgo   (txgo_a[g]),
         .txrdy  (txrdy_a[g]),
         .rxdout (rxdout_a[g]),
         .rxnew  (rxnew_a[g]),
         .MISO   (miso_a[g]),
         .MOSI   (mosi_a[g]),
         .SCLK   (sclk_a[g]),
         .SS1    (ss1_a[g])
      );
   end

   logic       m_txrdy, m_rxnew, m_mosi, m_sclk, m_ss1;
   logic [7:0] m_rxdout;
   assign m_txrdy  = txrdy_a[sel];
   assign m_rxnew  = rxnew_a[sel];
   assign m_mosi   = mosi_a[sel];
   assign m_sclk   = sclk_a[sel];
   assign m_ss1    = ss1_a[sel];
   assign m_rxdout = rxdout_a[sel];

   // MISO source: 0 = loopback of MOSI, 1 = tied low, 2 = slave returning slave_byte
   logic [1:0] miso_mode = 2'd0;
   logic [7:0] slave_byte = 8'h00;
   logic [3:0] s_cnt = 4'd0;
   logic [2:0] slave_idx;
   logic       miso_val;
   assign slave_idx = msb_of(int'(sel)) ? (3'd7 - s_cnt[2:0]) : s_cnt[2:0];
   assign miso_val  = (miso_mode == 2'd0) ? m_mosi :
                      (miso_mode == 2'd1) ? 1'b0 : slave_byte[slave_idx];
   for (genvar g = 0; g < 3; g++) begin : g_miso
      assign miso_a[g] = (sel == 2'(g)) ? miso_val : 1'b0;
   end

   // TX FIFO model and observation records
   logic [7:0] tx_buf [16];
   logic [3:0] wr_ptr = 4'd0, rd_ptr = 4'd0;
   logic       gate = 1'b0, mon_clr = 1'b0, will_load = 1'b0;
   logic       sclk_prev = 1'b0, ss1_prev = 1'b1;
   int         cyc = 0;
   int         ld_t[$], rx_t[$], ss1_rise_t[$];
   logic [7:0] rx_b[$];
   logic       mosi_bits[$];
   int         sclk_rises = 0, rxnew_cnt = 0;
   int         ncomp = 0, nfail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mon_clr) begin
         ld_t.delete(); rx_t.delete(); ss1_rise_t.delete();
         rx_b.delete(); mosi_bits.delete();
         sclk_rises = 0; rxnew_cnt = 0; s_cnt = 4'd0; will_load = 1'b0;
      end else begin
         if (will_load) rd_ptr = rd_ptr + 4'd1;
         drv_go    = gate && (rd_ptr != wr_ptr);
         txdin     = tx_buf[rd_ptr];
         will_load = (m_txrdy === 1'b1) && drv_go && !rst;
         if (will_load) ld_t.push_back(cyc + 1);
         if (m_rxnew === 1'b1) begin
            rx_b.push_back(m_rxdout);
            rx_t.push_back(cyc);
            rxnew_cnt++;
         end
         if (m_sclk === 1'b1 && !sclk_prev) begin
            sclk_rises++;
            mosi_bits.push_back(m_mosi);
            s_cnt = s_cnt + 4'd1;
         end
         if (m_ss1 === 1'b1 && !ss1_prev) ss1_rise_t.push_back(cyc);
         if (m_rxnew === 1'b1 || rst) s_cnt = 4'd0;
      end
      sclk_prev = (m_sclk === 1'b1);
      ss1_prev  = (m_ss1 === 1'b1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncomp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      tx_buf[wr_ptr] = b;
      wr_ptr = wr_ptr + 4'd1;
   endtask

   task automatic mon_clear();
      mon_clr = 1'b1;
      @(negedge clk); #1;
      mon_clr = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      logic ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk); #1;
         ok = (rd_ptr == wr_ptr) && !will_load && (m_txrdy === 1'b1) &&
              (m_ss1 === 1'b1) && (m_rxnew === 1'b0);
      end
      chk(tag, ok, 1'b1);
   endtask

   // Byte as it appeared on MOSI, first emitted bit in the MSB position.
   function automatic logic [7:0] mosi_byte(input int base);
      logic [7:0] v = 8'h00;
      for (int k = 0; k < 8; k++)
         if (base + k < mosi_bits.size()) v = {v[6:0], mosi_bits[base + k]};
      return v;
   endfunction

   function automatic logic [7:0] bit_rev(input logic [7:0] b);
      logic [7:0] r;
      for (int k = 0; k < 8; k++) r[k] = b[7 - k];
      return r;
   endfunction

   initial begin
      #600000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      logic [7:0] sent [8];
      logic [23:0] stream;
      int n, d, t;
      logic ok;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      mon_clear();

      // Reset/idle state
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("rst_ss1_%0d", g), ss1_a[g], 1'b1);
         chk($sformatf("rst_sclk_%0d", g), sclk_a[g], 1'b0);
         chk($sformatf("rst_mosi_%0d", g), mosi_a[g], 1'b1);
         chk($sformatf("rst_txrdy_%0d", g), txrdy_a[g], 1'b1);
         chk($sformatf("rst_rxnew_%0d", g), rxnew_a[g], 1'b0);
         chk($sformatf("rst_rxdout_%0d", g), rxdout_a[g], 8'h00);
      end
      repeat (100) @(negedge clk);
      #1 chk("idle_no_sclk", sclk_rises, 0);

      // Single byte, loopback, CLK_DIV=2
      sel = 2'd0; miso_mode = 2'd0; mon_clear();
      push(8'hA5); gate = 1'b1;
      wait_idle(300, "t1_timeout"); gate = 1'b0;
      chk("t1_rx_count", rx_b.size(), 1);
      chk("t1_rxdout", rx_b[0], 8'hA5);
      chk("t1_rxnew_time", rx_t[0], ld_t[0] + 34);
      chk("t1_rxnew_width", rxnew_cnt, 1);
      chk("t1_ss1_high_time", ss1_rise_t[0], ld_t[0] + 37);
      chk("t1_mosi", mosi_byte(0), 8'hA5);

      // Three queued bytes, MISO low, SS1 held across the burst
      sel = 2'd0; miso_mode = 2'd1; mon_clear();
      push(8'h01); push(8'h80); push(8'hFF); gate = 1'b1;
      wait_idle(600, "t2_timeout"); gate = 1'b0;
      chk("t2_loads", ld_t.size(), 3);
      chk("t2_ss1_rises", ss1_rise_t.size(), 1);
      chk("t2_sclk_rises", sclk_rises, 24);
      stream = {mosi_byte(0), mosi_byte(8), mosi_byte(16)};
      chk("t2_mosi_stream", stream, 24'h0180FF);
      chk("t2_rx_count", rx_b.size(), 3);
      for (int i = 0; i < 3; i++) chk($sformatf("t2_rx%0d", i), rx_b[i], 8'h00);
      chk("t2_chain_gap1", rx_t[1] - rx_t[0], 33);
      chk("t2_chain_gap2", rx_t[2] - rx_t[1], 33);

      // Random bursts with loopback on two divider settings
      for (int s = 0; s < 2; s++) begin
         sel = 2'(s); miso_mode = 2'd0; d = div_of(s); mon_clear();
         n = 3 + int'($urandom_range(0, 3));
         for (int i = 0; i < n; i++) begin
            sent[i] = 8'($urandom);
            push(sent[i]);
         end
         gate = 1'b1;
         wait_idle(3000, $sformatf("rnd%0d_timeout", s)); gate = 1'b0;
         chk($sformatf("rnd%0d_rx_count", s), rx_b.size(), n);
         t = (ld_t.size() > 0) ? ld_t[0] + 17 * d : 0;
         for (int i = 0; i < n; i++) begin
            chk($sformatf("rnd%0d_rx%0d", s, i), rx_b[i], sent[i]);
            chk($sformatf("rnd%0d_t%0d", s, i), rx_t[i], t);
            chk($sformatf("rnd%0d_mosi%0d", s, i), mosi_byte(8 * i), sent[i]);
            t = t + 16 * d + 1;
         end
      end

      // Reset mid-byte, CLK_DIV=4
      sel = 2'd1; miso_mode = 2'd0; mon_clear();
      push(8'h3C); gate = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk); #1;
         ok = (sclk_rises >= 3);
      end
      chk("t4_third_rise", ok, 1'b1);
      gate = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t4_ss1", m_ss1, 1'b1);
      chk("t4_sclk", m_sclk, 1'b0);
      chk("t4_txrdy", m_txrdy, 1'b1);
      chk("t4_mosi", m_mosi, 1'b1);
      repeat (100) @(negedge clk);
      #1 chk("t4_no_rxnew", rxnew_cnt, 0);
      chk("t4_no_more_sclk", sclk_rises, 3);
      mon_clear();
      push(8'hC3); gate = 1'b1;
      wait_idle(400, "t4b_timeout"); gate = 1'b0;
      chk("t4b_rx_count", rx_b.size(), 1);
      chk("t4b_rxdout", rx_b[0], 8'hC3);
      chk("t4b_mosi", mosi_byte(0), 8'hC3);

      // LSB-first with a slave returning 8'h5A, CLK_DIV=3
      sel = 2'd2; miso_mode = 2'd2; slave_byte = 8'h5A; mon_clear();
      push(8'hD2); gate = 1'b1;
      wait_idle(400, "t5_timeout"); gate = 1'b0;
      chk("t5_rxdout", rx_b[0], 8'h5A);
      chk("t5_mosi_lsb_first", mosi_byte(0), bit_rev(8'hD2));
      chk("t5_rxnew_time", rx_t[0], ld_t[0] + 51);

      // Byte offered during TRAIL waits for IDLE
      sel = 2'd0; miso_mode = 2'd0; mon_clear();
      push(8'h3A); gate = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk); #1;
         ok = (rx_b.size() == 1);
      end
      chk("t6_first_rx", ok, 1'b1);
      @(posedge clk); #1;
      push(8'h5C);
      wait_idle(300, "t6_timeout"); gate = 1'b0;
      chk("t6_loads", ld_t.size(), 2);
      chk("t6_ss1_rise", ss1_rise_t[0], rx_t[0] + 3);
      chk("t6_load_after_idle", ld_t[1], ss1_rise_t[0] + 1);
      chk("t6_rx2", rx_b[1], 8'h5C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

endmodule
